// File: rtl/shift_seq.sv
// -----------------------------------------------------------------------------
// shift_seq -- multicycle 32-bit shift unit for the execute stage.
//
// A request (operand, 5-bit amount, opcode) is latched on ctrl_start_i and then
// resolved one barrel-shifter stage per clock, largest stage first
// (16, 8, 4, 2, 1). A stage is applied only when the matching bit of the
// latched shift amount is set. The final value is flagged by a one-cycle
// ready pulse, so the pipeline can stall on this unit the same way it stalls
// on the mult/div unit.
//
// Optional feature macro: SHIFT_SEQ_ROTATE_EN
//   defined   : ctrl_op_i = 2'b11 performs rotate-right.
//   undefined : ctrl_op_i = 2'b11 behaves exactly like srl, and no rotate
//               wrap logic is built. Latency and handshake are the same.
//
// Ports:
//   clock_i          in   1  sole clock, rising edge
//   reset_i          in   1  asynchronous, active-high reset
//   ctrl_start_i     in   1  request strobe, honoured only in IDLE or DONE
//   ctrl_op_i        in   2  00 sll, 01 sra, 10 srl, 11 ror (or srl)
//   data_operand_i   in  32  value to shift, sampled with ctrl_start_i
//   data_shamt_i     in   5  shift amount 0..31, sampled with ctrl_start_i
//   data_result_o    out 32  working/result register
//   data_resultRDY_o out  1  high for exactly one cycle when result is final
//   busy_o           out  1  high while the shift stages are running
//
// Timing: accept at edge E0, stages at E1..E5 (k = 4..0), ready high between
// E5 and E6. A start seen during the ready cycle begins the next request
// without an idle gap (one request per 6 cycles).
// -----------------------------------------------------------------------------
module shift_seq (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        ctrl_start_i,
    input  logic [1:0]  ctrl_op_i,
    input  logic [31:0] data_operand_i,
    input  logic [4:0]  data_shamt_i,
    output logic [31:0] data_result_o,
    output logic        data_resultRDY_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b01;
    localparam logic [1:0] OP_SRL = 2'b10;

    state_t      state_q;
    logic [2:0]  k_q;          // current stage index, 4 down to 0
    logic [1:0]  op_q;
    logic [4:0]  shamt_q;
    logic [31:0] result_q;
    logic        rdy_q;
    logic        busy_q;

    // Shifted candidate for each stage size 2^gi, computed from the working
    // register; the sequencer picks the one selected by k_q.
    logic [31:0] stage_d [5];

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_stage
            localparam int N = 1 << gi;

            logic [31:0] sll_v;
            logic [31:0] srl_v;
            logic [31:0] sra_v;
            logic [31:0] sel_v;

            assign sll_v = {result_q[31-N:0], {N{1'b0}}};
            assign srl_v = {{N{1'b0}}, result_q[31:N]};
            // Bit 31 is never altered by earlier sra stages, so it is still
            // the original sign bit here.
            assign sra_v = {{N{result_q[31]}}, result_q[31:N]};

`ifdef SHIFT_SEQ_ROTATE_EN
            logic [31:0] ror_v;
            assign ror_v = {result_q[N-1:0], result_q[31:N]};
`endif

            always_comb begin
                sel_v = srl_v;
                case (op_q)
                    OP_SLL:  sel_v = sll_v;
                    OP_SRA:  sel_v = sra_v;
                    OP_SRL:  sel_v = srl_v;
                    default: begin
`ifdef SHIFT_SEQ_ROTATE_EN
                        sel_v = ror_v;
`else
                        sel_v = srl_v;
`endif
                    end
                endcase
            end

            assign stage_d[gi] = sel_v;
        end
    endgenerate

    // Single sequential block: state, latched request and registered outputs.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            k_q      <= 3'd4;
            op_q     <= 2'b00;
            shamt_q  <= 5'd0;
            result_q <= 32'h0000_0000;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    rdy_q <= 1'b0;
                    if (ctrl_start_i) begin
                        op_q     <= ctrl_op_i;
                        shamt_q  <= data_shamt_i;
                        result_q <= data_operand_i;
                        k_q      <= 3'd4;
                        busy_q   <= 1'b1;
                        state_q  <= ST_SHIFT;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end

                ST_SHIFT: begin
                    if (shamt_q[k_q]) begin
                        result_q <= stage_d[k_q];
                    end
                    if (k_q == 3'd0) begin
                        busy_q  <= 1'b0;
                        rdy_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        k_q <= k_q - 3'd1;
                    end
                end

                default: begin
                    rdy_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_result_o    = result_q;
    assign data_resultRDY_o = rdy_q;
    assign busy_o           = busy_q;

endmodule

// File: doc/shift_seq.md
# shift_seq

Multicycle shift unit for the processor's execute stage. Accepts one shift request (operand, 5-bit amount, opcode) and resolves it by applying one barrel-shifter stage per clock, largest stage first (16, 8, 4, 2, 1), using the same per-stage arithmetic-right-shift mux slices as the combinational shifter. Posts the result with a one-cycle ready pulse, so the pipeline can stall on it the same way it stalls on the mult/div unit.

## Interface
- No parameters; datapath fixed at 32 bits, shift amount at 5 bits.
- clock  in  1  — sole clock; all state updates on the rising edge.
- reset  in  1  — asynchronous, active-high; clears all state immediately.
- ctrl_start  in  1  — request strobe; sampled on the rising edge, honoured only in IDLE or DONE.
- ctrl_op  in  2  — operation select:
  - 00 = sll
  - 01 = sra
  - 10 = srl
  - 11 = ror (see Configuration)
- data_operand  in  32  — value to shift; sampled with ctrl_start.
- data_shamt  in  5  — shift amount 0–31; sampled with ctrl_start.
- data_result  out  32  — working/result register.
- data_resultRDY  out  1  — high for exactly one cycle when data_result is final.
- busy  out  1  — high while a shift is in progress (SHIFT state).

## Operation
- States:
  - IDLE: waiting.
  - SHIFT: stage index k counts 4 down to 0.
  - DONE: result posted.
- IDLE or DONE with ctrl_start=1:
  - Latch ctrl_op into op_q and data_shamt into shamt_q.
  - Load data_result ← data_operand.
  - Set k ← 4 and go to SHIFT.
- IDLE with ctrl_start=0: stay in IDLE.
- DONE with ctrl_start=0: go to IDLE.
- SHIFT, each cycle:
  - If shamt_q[k]=1, data_result ← data_result shifted by 2^k per op_q; otherwise unchanged.
  - If k=0, go to DONE; otherwise k ← k−1.
- Shift rules per stage of size n:
  - sll: zero-fill from bit 0.
  - srl: zero-fill from bit 31.
  - sra: replicate original bit 31 into the top n bits.
  - ror: bits shifted out of bit 0 re-enter at bit 31.
- Composing stages MSB-first yields exactly the single-shot result for every amount 0–31.
- data_resultRDY = (state==DONE).
- data_result holds its final value from DONE until the next accepted ctrl_start.
- ctrl_start during SHIFT is ignored: no latch, no effect, no queueing.
- Input changes while busy have no effect; only the latched copies are used.
- shamt=0: still takes the full 5 SHIFT cycles; result equals the operand.
- Reset at any time, including mid-SHIFT:
  - state=IDLE, k=4.
  - data_result=0, data_resultRDY=0, busy=0, op_q=0, shamt_q=0.
  - The in-flight request is discarded and no ready pulse is produced.
- Reset values of all outputs: data_result=0x00000000, data_resultRDY=0, busy=0.

## Timing
- Request accepted at edge E0.
- SHIFT stages run at edges E1..E5 (k=4..0). busy is high from after E0 until E5.
- State becomes DONE at E5; data_resultRDY is high for the single cycle between E5 and E6.
- Fixed latency: 6 edges from accepting edge to ready pulse deassertion; ready is visible 5 cycles after acceptance.
- Back-to-back: ctrl_start sampled high during DONE (edge E6) starts the next request with no idle gap. Throughput is 1 request per 6 cycles.
- All outputs come straight from registers; no combinational input-to-output path.

## Configuration
- Macro: SHIFT_SEQ_ROTATE_EN.
- Defined: ctrl_op=11 performs rotate-right, per stage as above.
- Undefined:
  - ctrl_op=11 is treated identically to srl.
  - No rotate wrap logic is synthesised.
  - Latency and handshake are unchanged.

## Test plan
- Reset, then sra 0x80000000 by 4 → busy high 5 cycles; data_resultRDY pulses one cycle 5 cycles after start; data_result=0xF8000000.
- sll 0x00000001 by 31 → 0x80000000; srl 0x80000000 by 31 → 0x00000001; sra 0x7FFFFFF0 by 31 → 0x00000000.
- sra 0x12345678 by 0 → 0x12345678 after the full 6-cycle latency.
- Start sra 0xF0000000 by 8, pulse ctrl_start again on cycle 2 with operand 0x1 → ignored; result 0xFFF00000. Then start in the DONE cycle → next request runs back-to-back.
- Assert reset during the 3rd SHIFT cycle → outputs go to 0 immediately, no ready pulse; a fresh request afterward completes normally.
- ctrl_op=11, 0x0000000F by 4:
  - with SHIFT_SEQ_ROTATE_EN → 0xF0000000.
  - without the macro → 0x00000000.
